lsu_mc: RTL
===========

Name: lsu_mc

Overview:
- Multi-cycle, parametrised load/store unit placed between the execute stage and the data-memory port.
- Accepts one load/store per valid/ready handshake and drives a request/grant/response memory interface.
- Splits word-boundary-crossing (misaligned) accesses into two bus beats and reassembles the load data.
- Supports DATA_WIDTH 32 or 64, with an error response for illegal or unsupported accesses.

Parameters:
- DATA_WIDTH, 32, bus and register data width; legal values are 32 and 64. NB = DATA_WIDTH/8.
- ADDR_WIDTH, 32, byte-address width.
- MISALIGN_SPLIT, 1, 1 = split boundary-crossing accesses; 0 = reject them with rsp_err.

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  unit can accept; equals (state==IDLE)
- lsuop  in  lsuop_t  operation. lsu_pkg is extended with LWU, LD and SD, which are legal only when DATA_WIDTH=64.
- addr_in  in  ADDR_WIDTH  byte address
- data_s_in  in  DATA_WIDTH  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  1  response carries an error
- data_l_out  out  DATA_WIDTH  sign- or zero-extended load result
- dmem_req  out  1  memory request
- dmem_gnt  in  1  memory accepts the request
- dmem_we  out  1  write enable
- dmem_addr  out  ADDR_WIDTH  NB-aligned beat address
- dmem_wdata  out  DATA_WIDTH  lane-positioned write data
- dmem_mask  out  NB  byte-lane enables
- dmem_rvalid  in  1  beat completion (read data or write acknowledge)
- dmem_rdata  in  DATA_WIDTH  read data
- dmem_err  in  1  bus error, valid together with dmem_rvalid

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - Reset mid-transaction drops dmem_req at once. Abandoning the in-flight memory beat is the memory's concern.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE:
  - On req_valid&&req_ready, capture lsuop, addr_in and data_s_in.
  - Compute size sz (B=1, H=2, W=4, D=8), offset off = addr[log2(NB)-1:0] and split = (off+sz > NB).
  - Go to RESP with err=1 (no bus access) when any of these holds:
    - lsuop is illegal;
    - LWU/LD/SD is used with DATA_WIDTH=32;
    - split=1 and MISALIGN_SPLIT=0.
  - Otherwise go to REQ0.
- REQ0:
  - dmem_req=1, dmem_addr = addr with the low offset bits cleared.
  - dmem_mask = ((1<<sz)-1)<<off, truncated to NB bits.
  - dmem_wdata = data<<(8*off).
  - dmem_we is 1 for stores.
  - dmem_req, dmem_addr, dmem_wdata, dmem_mask and dmem_we are held stable until dmem_gnt; on dmem_gnt go to WAIT0.
- WAIT0: on dmem_rvalid, store dmem_rdata in beat0. Then:
  - if dmem_err: go to RESP with err=1 (beat1 is skipped);
  - else if split: go to REQ1;
  - else: go to RESP.
- dmem_rvalid arrives no earlier than the cycle after dmem_gnt. dmem_rvalid seen outside a WAIT state is ignored.
- REQ1:
  - dmem_addr = aligned address + NB, wrapping modulo 2^ADDR_WIDTH.
  - dmem_mask = ((1<<sz)-1)>>(NB-off).
  - dmem_wdata = data>>(8*(NB-off)).
  - Same hold rule as REQ0.
- WAIT1: store dmem_rdata in beat1; err = dmem_err; go to RESP.
- Load assembly: raw = ({beat1,beat0} >> 8*off). Take the low sz bytes, then:
  - LB/LH/LW/LD sign-extend;
  - LBU/LHU/LWU zero-extend.
- RESP:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - data_l_out and rsp_err are registered and valid only while rsp_valid=1; they are 0 otherwise.
  - On any error, or for a store, data_l_out=0.
- Latency (aligned access, same-cycle gnt, rvalid one cycle later):
  - accept at T, dmem_req at T+1, rvalid at T+2, rsp_valid at T+3;
  - a split access adds 2 cycles minimum;
  - an illegal or rejected access responds at T+1.
- Throughput: one outstanding request. req_ready=0 from the cycle after acceptance until the cycle after RESP.

Test Plan:
- LW addr 0x100, gnt immediate, rdata 0x87654321 -> single beat, dmem_addr 0x100, mask 4'b1111, rsp_valid at T+3, data_l_out 0x87654321.
- SH addr 0x203, data 0xABCD -> beat0 addr 0x200, mask 4'b1000, wdata[31:24]=0xCD; beat1 addr 0x204, mask 4'b0001, wdata[7:0]=0xAB; one rsp_valid, rsp_err 0.
- LH addr 0x1003, beat0 rdata 0x80000000, beat1 rdata 0x000000FF -> data_l_out 0xFFFFFF80; the same sequence with LHU -> 0x0000FF80.
- LB addr 0x3, rdata 0x80000000 -> 0xFFFFFF80; LBU -> 0x00000080. DATA_WIDTH=64: LD addr 0x8 -> mask 8'hFF, full 64-bit result.
- dmem_gnt held low 5 cycles -> dmem_req, addr, wdata and mask stable throughout, req_ready 0. In a separate split access, dmem_err on beat0 -> no REQ1, rsp_err 1, data_l_out 0.
- arst asserted in WAIT1 -> dmem_req 0 immediately, req_ready 1, no rsp_valid. MISALIGN_SPLIT=0 with LW addr 0x2 -> no dmem_req, rsp_valid with rsp_err 1 at T+1. SD with DATA_WIDTH=32 -> rsp_err 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Load/store operation encodings shared by the LSU, its interface and the bench.
// Codes above LSU_SD are reserved and are answered with an error response.
package lsu_pkg;

    typedef logic [3:0] lsuop_t;

    localparam lsuop_t LSU_LB  = 4'd0;
    localparam lsuop_t LSU_LH  = 4'd1;
    localparam lsuop_t LSU_LW  = 4'd2;
    localparam lsuop_t LSU_LBU = 4'd3;
    localparam lsuop_t LSU_LHU = 4'd4;
    localparam lsuop_t LSU_SB  = 4'd5;
    localparam lsuop_t LSU_SH  = 4'd6;
    localparam lsuop_t LSU_SW  = 4'd7;
    localparam lsuop_t LSU_LWU = 4'd8;
    localparam lsuop_t LSU_LD  = 4'd9;
    localparam lsuop_t LSU_SD  = 4'd10;

endpackage

// File: rtl/lsu_mc_if.sv
// Execute-side request/response and data-memory port of the LSU.
// The slave modport is the LSU itself; master is the surrounding pipeline and memory.
interface lsu_mc_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    localparam int NB = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    lsu_pkg::lsuop_t       lsuop;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic [DATA_WIDTH-1:0] data_s_in;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] data_l_out;
    logic                  dmem_req;
    logic                  dmem_gnt;
    logic                  dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [NB-1:0]         dmem_mask;
    logic                  dmem_rvalid;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_err;

    modport slave (
        input  req_valid, lsuop, addr_in, data_s_in,
        input  dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err,
        output req_ready, rsp_valid, rsp_err, data_l_out,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask
    );

    modport master (
        output req_valid, lsuop, addr_in, data_s_in,
        output dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err,
        input  req_ready, rsp_valid, rsp_err, data_l_out,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_mask
    );

endinterface

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: one outstanding access, word-crossing accesses split
// into two aligned bus beats with load data reassembled and sign/zero-extended.
module lsu_mc
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic    clk,
    input  logic    arst,
    lsu_mc_if.slave bus
);

    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(NB);
    localparam int SBW  = $clog2(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] NB_A = ADDR_WIDTH'(NB);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    function automatic logic [3:0] op_size(input lsuop_t op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: op_size = 4'd1;
            LSU_LH, LSU_LHU, LSU_SH: op_size = 4'd2;
            LSU_LD, LSU_SD:          op_size = 4'd8;
            default:                 op_size = 4'd4;
        endcase
    endfunction

    function automatic logic op_legal(input lsuop_t op);
        logic wide_only;
        wide_only = (op == LSU_LWU) || (op == LSU_LD) || (op == LSU_SD);
        op_legal  = (op <= LSU_SD) && !(DATA_WIDTH == 32 && wide_only);
    endfunction

    function automatic logic op_store(input lsuop_t op);
        op_store = (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW) || (op == LSU_SD);
    endfunction

    function automatic logic op_signed(input lsuop_t op);
        op_signed = (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) || (op == LSU_LD);
    endfunction

    logic [2:0]            state_q, state_d;
    lsuop_t                op_q, op_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] beat0_q, beat0_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [3:0]            sz_in, sz_q;
    logic [OFFW-1:0]       off_in, off_q;
    logic                  split_in, split_q;
    logic [ADDR_WIDTH-1:0] base_addr, next_addr;
    logic [2*NB-1:0]       sz_mask, wide_mask;
    logic [2*DATA_WIDTH-1:0] wide_wdata;
    logic                  in_req, in_req1;

    assign sz_in    = op_size(bus.lsuop);
    assign off_in   = bus.addr_in[OFFW-1:0];
    assign split_in = (int'(off_in) + int'(sz_in)) > NB;
    assign sz_q     = op_size(op_q);
    assign off_q    = addr_q[OFFW-1:0];
    assign split_q  = (int'(off_q) + int'(sz_q)) > NB;

    assign base_addr = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    assign next_addr = base_addr + NB_A;

    // Byte enables and store data are formed across two words; the upper half is beat1.
    for (genvar gi = 0; gi < 2 * NB; gi++) begin : g_sz_mask
        assign sz_mask[gi] = (gi < int'(sz_q));
    end
    assign wide_mask  = sz_mask << off_q;
    assign wide_wdata = {{DATA_WIDTH{1'b0}}, data_q} << {off_q, 3'b000};

    assign in_req  = (state_q == S_REQ0) || (state_q == S_REQ1);
    assign in_req1 = (state_q == S_REQ1);

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.dmem_req   = in_req;
    assign bus.dmem_we    = in_req && op_store(op_q);
    assign bus.dmem_addr  = !in_req ? '0 : (in_req1 ? next_addr : base_addr);
    assign bus.dmem_mask  = !in_req ? '0 :
                            (in_req1 ? wide_mask[2*NB-1:NB] : wide_mask[NB-1:0]);
    assign bus.dmem_wdata = !in_req ? '0 :
                            (in_req1 ? wide_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : wide_wdata[DATA_WIDTH-1:0]);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.data_l_out = rsp_data_q;

    // Load assembly reads the live bus data in the cycle the last beat completes.
    logic [DATA_WIDTH-1:0] ld_b0, ld_b1, ld_raw, ld_mask, ld_result;
    logic [SBW-1:0]        ld_sbit;
    logic                  ld_neg;

    assign ld_b0   = (state_q == S_WAIT0) ? bus.dmem_rdata : beat0_q;
    assign ld_b1   = (state_q == S_WAIT1) ? bus.dmem_rdata : '0;
    assign ld_raw  = DATA_WIDTH'({ld_b1, ld_b0} >> {off_q, 3'b000});
    assign ld_sbit = SBW'({sz_q, 3'b000} - 7'd1);
    assign ld_neg  = op_signed(op_q) && ld_raw[ld_sbit];
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_ld_mask
        assign ld_mask[gi] = (gi < 8 * int'(sz_q));
    end
    assign ld_result = (ld_raw & ld_mask) | (ld_neg ? ~ld_mask : '0);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        beat0_d     = beat0_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d   = bus.lsuop;
                    addr_d = bus.addr_in;
                    data_d = bus.data_s_in;
                    if (!op_legal(bus.lsuop) || (split_in && MISALIGN_SPLIT == 0)) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ0;
                    end
                end
            end
            S_REQ0: if (bus.dmem_gnt) state_d = S_WAIT0;
            S_WAIT0: begin
                if (bus.dmem_rvalid) begin
                    beat0_d = bus.dmem_rdata;
                    if (bus.dmem_err) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (split_q) begin
                        state_d = S_REQ1;
                    end else begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = op_store(op_q) ? '0 : ld_result;
                    end
                end
            end
            S_REQ1: if (bus.dmem_gnt) state_d = S_WAIT1;
            S_WAIT1: begin
                if (bus.dmem_rvalid) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.dmem_err;
                    rsp_data_d  = (bus.dmem_err || op_store(op_q)) ? '0 : ld_result;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= S_IDLE;
            op_q        <= LSU_LB;
            addr_q      <= '0;
            data_q      <= '0;
            beat0_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            beat0_q     <= beat0_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule
